sorted_stream_serializer: RTL
=============================

// Module: sorted_stream_serializer
// PURPOSE
//  Drains one 8-word result vector from the bitonicSort network and emits it
//  one word per beat on a valid/ready stream, ascending or descending.
//  Sits downstream of the sorter: the sorter's out1..out8 feed in1..in8 here.
//  Handles downstream backpressure, marks the last beat and reports busy.
// PARAMETERS
//  WIDTH  8  bit width of each data word, matching the sorter's WIDTH
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  rst         in   1      synchronous, active-high reset
//  load_valid  in   1      in1..in8 and desc hold a sorted vector to capture
//  load_ready  out  1      block is idle and can accept a vector
//  in1..in8    in   WIDTH  sorted words, in1 = smallest ... in8 = largest
//  desc        in   1      order select, sampled with the load: 0 = in1 first, 1 = in8 first
//  m_valid     out  1      m_data/m_last/m_index carry a valid beat
//  m_ready     in   1      downstream accepts the current beat
//  m_data      out  WIDTH  current output word
//  m_last      out  1      current beat is the 8th word of the vector
//  m_index     out  3      beat number within the vector, 0..7
//  busy        out  1      a vector is captured and not yet fully drained
// BEHAVIOUR
//  - All outputs are registered. Reset values: load_ready=1, m_valid=0,
//    m_data=0, m_last=0, m_index=0, busy=0. The internal vector is cleared to 0.
//  - States:
//    - IDLE: busy=0, load_ready=1.
//    - DRAIN: busy=1, load_ready=0, m_valid=1.
//  - Load accept = load_valid & load_ready (only possible in IDLE). On accept at
//    edge T, capture all 8 words and desc, and go to DRAIN.
//  - First beat is presented from T+1: m_index=0 and m_data=in1 (desc=0) or
//    in8 (desc=1). Load-to-first-beat latency is 1 cycle.
//  - Beat transfer = m_valid & m_ready. On transfer the next word is presented
//    the following cycle, with m_index+1.
//  - While m_valid=1 & m_ready=0: m_data, m_index and m_last hold stable; no
//    skipped or duplicated words.
//  - m_last=1 exactly when m_index=7. The transfer of that beat returns the
//    block to IDLE: m_valid=0, busy=0, load_ready=1 on the next cycle.
//  - No overlap of vectors: peak throughput is 8 words per 9 cycles.
//  - load_valid while busy has no effect (load_ready=0). The captured data and
//    desc cannot change mid-drain.
//  - in1..in8 and desc are don't-care except in the accept cycle.
//  - m_index counter stays in 0..7; it never wraps past 7 within a vector.
//  - rst asserted in any state, including mid-drain: the next cycle shows all
//    reset values. The partial vector is discarded and the next load works
//    normally. rst has priority over a simultaneous load or transfer.
//  - Word values are passed through unmodified. The block does not check
//    that the input is sorted.
// TESTING
//  1 Reset: hold rst 2 cycles -> load_ready=1, m_valid=0, m_data=0, busy=0.
//  2 Ascending: in1..in8 = 3,7,12,20,33,41,90,255, desc=0, load at T,
//    m_ready=1 -> m_data 3..255 on T+1..T+8, m_index 0..7, m_last only at
//    T+8, load_ready=1 at T+9.
//  3 Descending: same data with desc=1 -> m_data 255,90,41,33,20,12,7,3;
//    m_last with 3.
//  4 Backpressure: ascending vector, drop m_ready for 3 cycles when
//    m_index=2 -> m_data=12 held 3 extra cycles, then 20; 8 transfers total.
//  5 Load while busy: at m_index=4 pulse load_valid with all words=0xAA,
//    desc=1 -> ignored; remaining words stay 33,41,90,255.
//  6 Reset mid-drain: rst at m_index=5 -> next cycle m_valid=0,
//    load_ready=1; a new load of 1..8 (desc=0) then drains 1..8 correctly.

Source files
------------

// File: rtl/sorted_stream_serializer.sv
// Serialises one captured 8-word sorted vector onto a valid/ready stream,
// ascending (in1 first) or descending (in8 first), with last-beat and index tags.
module sorted_stream_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [WIDTH-1:0] in8,
    input  logic             desc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [2:0]       m_index,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] vec [8];
    logic             desc_q;
    logic [2:0]       nxt_idx;
    logic [WIDTH-1:0] nxt_word;

    // Word for the beat after the one currently presented.
    always_comb begin
        nxt_idx  = m_index + 3'd1;
        nxt_word = desc_q ? vec[3'd7 - nxt_idx] : vec[nxt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_index    <= '0;
            busy       <= 1'b0;
            desc_q     <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                vec[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        vec[0]     <= in1;
                        vec[1]     <= in2;
                        vec[2]     <= in3;
                        vec[3]     <= in4;
                        vec[4]     <= in5;
                        vec[5]     <= in6;
                        vec[6]     <= in7;
                        vec[7]     <= in8;
                        desc_q     <= desc;
                        // First beat comes straight from the inputs for 1-cycle latency.
                        m_data     <= desc ? in8 : in1;
                        m_index    <= '0;
                        m_last     <= 1'b0;
                        m_valid    <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid    <= 1'b0;
                            m_last     <= 1'b0;
                            m_index    <= '0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            m_data  <= nxt_word;
                            m_index <= nxt_idx;
                            m_last  <= (nxt_idx == 3'd7);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
